// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writer side of the instruction memory. It receives a byte stream over a
//   valid/ready handshake. The stream is a big-endian 16-bit word count N,
//   followed by N big-endian 16-bit instruction words. The words are written
//   to the instruction RAM in order, starting at word address 0. The core is
//   held stalled until a load completes without error.
//
// Optional feature (macro IMEM_LOADER_CHECKSUM_EN):
//   When the macro is defined, one trailing checksum byte is accepted after
//   the last word, and also when N == 0. The byte must equal the XOR of all
//   2N data bytes; the length bytes are not included. If it does not match,
//   error is raised. When the macro is undefined, there is no checksum byte
//   and error is set only by a length overflow.
//
// Parameters:
//   ADDR_WIDTH   - word address width; the RAM holds 2**ADDR_WIDTH words.
//                  Supported range is 1 to 16.
//
// Ports:
//   i_clk        - system clock; all state changes on the rising edge
//   i_reset      - asynchronous, active-high reset
//   i_start      - single-cycle pulse; begins a load (honoured in IDLE/DONE)
//   i_byte_in    - stream data byte
//   i_byte_valid - i_byte_in holds a valid byte
//   o_byte_ready - loader can accept a byte this cycle (depends on state only)
//   o_mem_we     - instruction RAM write enable (one cycle per word)
//   o_mem_addr   - instruction RAM word address
//   o_mem_wdata  - instruction word to write
//   o_core_hold  - 1 = core stalled; released only after a clean load
//   o_busy       - load in progress
//   o_done       - load finished; sticky until the next start or reset
//   o_error      - load failed; sticky until the next start or reset
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_byte_in,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_wdata,
  output logic                  o_core_hold,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  // The counter is one bit wider than the address.
  // This lets N == 2**ADDR_WIDTH be expressed without wrapping.
  localparam int          CNT_W    = ADDR_WIDTH + 1;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  // After the final word (or an empty load), the FSM goes to CHECK when the
  // checksum is enabled, and straight to DONE otherwise.
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHECK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  state_t            r_state;
  state_t            w_state_next;
  logic [15:0]       r_len;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_data_hi;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_ready;
  logic              w_accept;
  logic [15:0]       w_len_full;
  logic              w_len_zero;
  logic              w_len_over;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_last_word;

  // Ready depends on the state alone, never on i_byte_valid.
  // This keeps the source free of combinational paths back into it.
  always_comb begin
    w_ready = 1'b0;
    case (r_state)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO: w_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK:                                  w_ready = 1'b1;
`endif
      default:                                  w_ready = 1'b0;
    endcase
  end

  assign w_accept    = i_byte_valid & w_ready;

  // w_len_full is the length as it becomes complete on the LEN_LO accept edge.
  assign w_len_full  = {r_len[15:8], i_byte_in};
  assign w_len_zero  = (w_len_full == 16'h0000);
  assign w_len_over  = ({1'b0, w_len_full} > CAPACITY);

  assign w_count_inc = r_count + 1'b1;
  assign w_last_word = (32'(w_count_inc) == 32'(r_len));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_state_next = r_state;
    o_byte_ready = w_ready;
    o_mem_we     = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_core_hold  = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_state_next = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (w_accept) begin
          w_state_next = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_accept) begin
          if (w_len_over) begin
            w_state_next = S_DONE;
          end else if (w_len_zero) begin
            w_state_next = S_AFTER_DATA;
          end else begin
            w_state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (w_accept) begin
          w_state_next = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (w_accept) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_mem_we     = 1'b1;
        w_state_next = w_last_word ? S_AFTER_DATA : S_DATA_HI;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (w_accept) begin
          w_state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        o_busy      = 1'b0;
        o_done      = 1'b1;
        // A failed load keeps the core stalled.
        o_core_hold = r_error;
        if (i_start) begin
          w_state_next = S_LEN_HI;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: length capture, word assembly, write address/data, error flag
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_len       <= '0;
      r_count     <= '0;
      r_data_hi   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_count <= '0;
            r_error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len[15:8] <= i_byte_in;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= i_byte_in;
            if (w_len_over) begin
              r_error <= 1'b1;
            end
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            r_data_hi <= i_byte_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ i_byte_in;
`endif
          end
        end
        S_DATA_LO: begin
          // Address and data are registered here.
          // They are then stable for the whole WRITE cycle.
          // They keep their values until the next word.
          if (w_accept) begin
            r_mem_addr  <= r_count[ADDR_WIDTH-1:0];
            r_mem_wdata <= {r_data_hi, i_byte_in};
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= r_csum ^ i_byte_in;
`endif
          end
        end
        S_WRITE: begin
          r_count <= w_count_inc;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept && (i_byte_in != r_csum)) begin
            r_error <= 1'b1;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_error     = r_error;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory.
- The pipeline's fetch stage only reads instruction memory.
- This block receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words and writes them sequentially from address 0.
- It holds the core stalled until a load completes cleanly. It sits between an external byte source (debug link) and the write port of the instruction RAM, and drives the core hold/stall input.

Parameters:
- ADDR_WIDTH, 8: width of the instruction RAM word address; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a load (sampled in IDLE or DONE)
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in holds a valid byte
- byte_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  instruction RAM write enable
- mem_addr  out  ADDR_WIDTH  instruction RAM word address
- mem_wdata  out  16  instruction word to write
- core_hold  out  1  high = core kept stalled (fetch/PC frozen)
- busy  out  1  load in progress
- done  out  1  load finished; sticky until next start or reset
- error  out  1  load failed; sticky until next start or reset

Behaviour:
- Reset (async, any state): state=IDLE, word counter=0, length=0, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, core_hold=1. RAM contents already written are untouched.
- Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready.
  - byte_ready=1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO (and CHECK with the optional feature).
  - byte_ready is combinational from state only, never from byte_valid.
- Stream format: 16-bit word count N, big-endian (high byte first), then N words, each big-endian.
- FSM states and transitions:
  - IDLE: start -> LEN_HI; on that edge busy=1, done=0, error=0, core_hold=1, counter=0.
  - LEN_HI: accept -> N[15:8], go LEN_LO.
  - LEN_LO: accept -> N[7:0]. Then:
    - if N==0 -> DONE, no writes;
    - else if N > 2**ADDR_WIDTH -> DONE with error=1, no writes;
    - else -> DATA_HI.
  - DATA_HI: accept -> wdata[15:8], go DATA_LO.
  - DATA_LO: accept -> wdata[7:0], go WRITE.
  - WRITE: exactly one cycle.
    - mem_we=1, mem_addr=counter, mem_wdata=assembled word.
    - The write is visible the cycle after the low byte is accepted.
    - On exit counter+1; if counter+1==N -> DONE (CHECK with feature), else DATA_HI.
  - DONE: busy=0, done=1. core_hold=0 if error==0, core_hold stays 1 if error==1. start -> LEN_HI, clearing done/error and reasserting core_hold and busy.
- start is ignored in LEN_HI..WRITE; a load cannot be restarted except by reset.
- mem_we is 0 in every state except WRITE. mem_addr/mem_wdata hold their last values otherwise.
- Counter is ADDR_WIDTH+1 bits wide, so N == 2**ADDR_WIDTH is legal: last address 2**ADDR_WIDTH-1, no wrap.
- A stalled source (byte_valid low) leaves the FSM in its current state indefinitely; there is no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the FSM enters CHECK with byte_ready=1 and accepts one byte.
  - That byte is compared to the XOR of all 2N data bytes (length bytes excluded).
  - Mismatch -> error=1. Either way, next state is DONE.
  - N==0 also passes through CHECK; the expected value is 0x00.
- Undefined: no CHECK state; the last WRITE goes directly to DONE and error is set only by the length overflow.

Test Plan:
- Reset then idle 10 cycles -> core_hold=1, byte_ready=0, mem_we=0, done=0, busy=0.
- start, stream 00 02 12 34 AB CD with byte_valid held high -> mem_we pulses at addr 0 data 0x1234 and addr 1 data 0xABCD, one cycle after each low byte; then done=1, core_hold=0, error=0.
- Same stream with byte_valid toggling every other cycle -> identical writes and final flags; no byte lost or duplicated.
- ADDR_WIDTH=8, stream 01 01 (N=257) -> no mem_we ever, done=1, error=1, core_hold=1. With N=256 all 256 writes occur, last addr 0xFF.
- Assert reset after the 3rd data byte of a 4-word load -> outputs return to reset values immediately; new start with 00 01 55 AA writes 0x55AA at addr 0.
- IMEM_LOADER_CHECKSUM_EN defined:
  - stream 00 01 12 34 26 -> done=1, error=0;
  - trailing byte 27 -> error=1, core_hold=1.
